cpu_clock_ctrl: RTL and testbench



---
 rtl/cpu_clock_pkg.sv | 11 +
 rtl/debounce.sv | 40 ++++
 rtl/cpu_clock_ctrl.sv | 137 +++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clock_pkg.sv
// Shared types for the CPU run/step/halt clock controller.
package cpu_clock_pkg;
   typedef enum logic [1:0] {
      S_HALT = 2'd0,
      S_RUN  = 2'd1,
      S_STEP = 2'd2,
      S_BRK  = 2'd3
   } state_t;

   localparam int CYCLE_W = 32;
endpackage

// File: rtl/debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a rising-edge pulse.
module debounce #(
   parameter int N = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise
);
   localparam int CW = $clog2(N + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         dout  <= 1'b0;
         rise  <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         rise  <= 1'b0;
         // Any return to the accepted level restarts the stability window.
         if (sync2 == dout) begin
            cnt <= '0;
         end else if (cnt == CW'(N - 1)) begin
            dout <= sync2;
            rise <= sync2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable controller: divided RUN pulses, debounced single steps, break on halt_req.
// Optional macro CPU_CLOCK_RUN_LIMIT_EN adds run_limit: stop to S_BRK after that many RUN pulses.
module cpu_clock_ctrl
   import cpu_clock_pkg::*;
#(
   parameter int DIV_W       = 32,
   parameter int DEFAULT_DIV = 5000000,
   parameter int DEBOUNCE_N  = 100000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode_run,
   input  logic               step_btn,
   input  logic [DIV_W-1:0]   div_cfg,
   input  logic               div_load,
   input  logic               halt_req,
`ifdef CPU_CLOCK_RUN_LIMIT_EN
   input  logic [31:0]        run_limit,
`endif
   output logic               cpu_en,
   output logic               clk_div,
   output state_t             state,
   output logic [CYCLE_W-1:0] cycle_count
);
   state_t           nxt;
   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] counter;
   logic [DIV_W-1:0] cnt_nxt;
   logic             en_nxt;
   logic             ret_brk;
   logic             ret_nxt;
   logic             btn_level;
   logic             step_event;
`ifdef CPU_CLOCK_RUN_LIMIT_EN
   logic [31:0]      run_cnt;
   logic [31:0]      run_nxt;
`endif

   debounce #(.N(DEBOUNCE_N)) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .din  (step_btn),
      .dout (btn_level),
      .rise (step_event)
   );

   always_comb begin
      nxt     = state;
      cnt_nxt = counter;
      en_nxt  = 1'b0;
      ret_nxt = ret_brk;
`ifdef CPU_CLOCK_RUN_LIMIT_EN
      run_nxt = run_cnt;
`endif
      case (state)
         S_HALT: begin
            if (mode_run) begin
               nxt     = S_RUN;
               cnt_nxt = '0;
`ifdef CPU_CLOCK_RUN_LIMIT_EN
               run_nxt = '0;
`endif
            end else if (step_event) begin
               ret_nxt = 1'b0;
               nxt     = S_STEP;
               en_nxt  = 1'b1;
            end
         end
         S_RUN: begin
            // halt_req wins over a terminal count in the same cycle.
            if (halt_req) begin
               nxt = S_BRK;
`ifdef CPU_CLOCK_RUN_LIMIT_EN
            end else if (run_limit != '0 && run_cnt == run_limit) begin
               nxt = S_BRK;
`endif
            end else if (!mode_run) begin
               nxt = S_HALT;
            end else if (counter == div_reg) begin
               en_nxt  = 1'b1;
               cnt_nxt = '0;
`ifdef CPU_CLOCK_RUN_LIMIT_EN
               run_nxt = run_cnt + 32'd1;
`endif
            end else begin
               cnt_nxt = counter + DIV_W'(1);
            end
         end
         S_STEP: begin
            nxt = ret_brk ? S_BRK : S_HALT;
         end
         S_BRK: begin
            if (!mode_run) begin
               nxt = S_HALT;
            end else if (step_event) begin
               ret_nxt = 1'b1;
               nxt     = S_STEP;
               en_nxt  = 1'b1;
            end
         end
         default: nxt = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_HALT;
         div_reg     <= DIV_W'(DEFAULT_DIV);
         counter     <= '0;
         ret_brk     <= 1'b0;
         cpu_en      <= 1'b0;
         clk_div     <= 1'b0;
         cycle_count <= '0;
`ifdef CPU_CLOCK_RUN_LIMIT_EN
         run_cnt     <= '0;
`endif
      end else begin
         state   <= nxt;
         ret_brk <= ret_nxt;
         cpu_en  <= en_nxt;
         // A load restarts the period but never cancels an already-decided pulse.
         counter <= div_load ? '0 : cnt_nxt;
         if (div_load)
            div_reg <= div_cfg;
         if (en_nxt) begin
            clk_div     <= ~clk_div;
            cycle_count <= cycle_count + CYCLE_W'(1);
         end
`ifdef CPU_CLOCK_RUN_LIMIT_EN
         run_cnt <= run_nxt;
`endif
      end
   end

   logic unused_level;
   assign unused_level = btn_level;
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Self-checking bench for cpu_clock_ctrl (DEFAULT_DIV=3, DEBOUNCE_N=4).
module tb_cpu_clock_ctrl;
   localparam logic [1:0] ST_HALT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_STEP = 2'd2;
   localparam logic [1:0] ST_BRK  = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode_run;
   logic        step_btn;
   logic [31:0] div_cfg;
   logic        div_load;
   logic        halt_req;
   logic        cpu_en;
   logic        clk_div;
   cpu_clock_pkg::state_t state;
   logic [31:0] cycle_count;
`ifdef CPU_CLOCK_RUN_LIMIT_EN
   logic [31:0] run_limit;
`endif

   int          n_assert = 0;
   int          n_fail   = 0;
   int unsigned exp_cnt  = 0;
   logic        exp_div  = 1'b0;

   always #5 clk = ~clk;

   cpu_clock_ctrl #(.DIV_W(32), .DEFAULT_DIV(3), .DEBOUNCE_N(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .mode_run    (mode_run),
      .step_btn    (step_btn),
      .div_cfg     (div_cfg),
      .div_load    (div_load),
      .halt_req    (halt_req),
`ifdef CPU_CLOCK_RUN_LIMIT_EN
      .run_limit   (run_limit),
`endif
      .cpu_en      (cpu_en),
      .clk_div     (clk_div),
      .state       (state),
      .cycle_count (cycle_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_count"}, cycle_count, exp_cnt);
      chk({tag, "_clkdiv"}, {31'd0, clk_div}, {31'd0, exp_div});
   endtask

   // From the cycle the RUN period (re)starts, pulses land every d+1 cycles, first at k=d+2.
   task automatic run_window(input int d, input int ncyc);
      logic exp_en;
      for (int k = 1; k <= ncyc; k++) begin
         tick();
         div_load = 1'b0;
         exp_en = (k >= 2) && (((k - 1) % (d + 1)) == 0);
         chk("run_en", {31'd0, cpu_en}, {31'd0, exp_en});
         chk("run_state", 32'(state), 32'(ST_RUN));
         if (exp_en) begin
            exp_cnt++;
            exp_div = ~exp_div;
         end
         chk_counts("run");
      end
   endtask

   // Bouncy press then release: exactly one step pulse, then back to end_st.
   task automatic press(input logic [1:0] end_st);
      int pulses = 0;
      for (int i = 0; i < 25; i++) begin
         if (i < 3) step_btn = 1'($urandom_range(0, 1));
         else if (i < 13) step_btn = 1'b1;
         else step_btn = 1'b0;
         tick();
         if (cpu_en === 1'b1) begin
            pulses++;
            chk("step_state", 32'(state), 32'(ST_STEP));
         end
      end
      chk("step_pulses", pulses, 1);
      chk("step_end_state", 32'(state), 32'(end_st));
      exp_cnt++;
      exp_div = ~exp_div;
      chk_counts("step");
   endtask

   initial begin
      int d;
      int r;
      logic found;
      rst = 1'b1; mode_run = 1'b0; step_btn = 1'b0;
      div_cfg = '0; div_load = 1'b0; halt_req = 1'b0;
`ifdef CPU_CLOCK_RUN_LIMIT_EN
      run_limit = '0;
`endif
      tick(); tick();
      chk("rst_state", 32'(state), 32'(ST_HALT));
      chk("rst_en", {31'd0, cpu_en}, 32'd0);
      chk_counts("rst");
      rst = 1'b0;
      tick();
      chk("idle_state", 32'(state), 32'(ST_HALT));

      // Default divider: three pulses spaced 4 cycles apart.
      mode_run = 1'b1;
      run_window(3, 13);
      chk("run3_clkdiv", {31'd0, clk_div}, 32'd1);
      chk("run3_count", cycle_count, 32'd3);

      repeat (2) begin
         d = $urandom_range(1, 6);
         div_cfg = d; div_load = 1'b1;
         run_window(d, 1 + 2 * (d + 1));
      end

      div_cfg = 0; div_load = 1'b1;
      run_window(0, 6);
      mode_run = 1'b0;
      tick();
      chk("div0_stop_state", 32'(state), 32'(ST_HALT));
      chk("div0_stop_en", {31'd0, cpu_en}, 32'd0);
      chk_counts("div0_stop");

      div_cfg = 3; div_load = 1'b1;
      tick();
      div_load = 1'b0;
      chk("load_halt_en", {31'd0, cpu_en}, 32'd0);

      press(ST_HALT);

      // halt_req lands on the cycle the terminal count would fire.
      mode_run = 1'b1;
      r = $urandom_range(0, 2);
      run_window(3, 4 + 4 * r);
      halt_req = 1'b1;
      tick();
      chk("brk_en", {31'd0, cpu_en}, 32'd0);
      chk("brk_state", 32'(state), 32'(ST_BRK));
      chk_counts("brk");
      tick();
      chk("brk_hold_state", 32'(state), 32'(ST_BRK));
      halt_req = 1'b0;
      press(ST_BRK);
      mode_run = 1'b0;
      tick();
      chk("brk_exit_state", 32'(state), 32'(ST_HALT));

      // Reset while a step pulse is in flight.
      step_btn = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (state === cpu_clock_pkg::S_STEP) found = 1'b1;
      end
      chk("step_seen", {31'd0, found}, 32'd1);
      rst = 1'b1; step_btn = 1'b0;
      tick();
      rst = 1'b0;
      exp_cnt = 0; exp_div = 1'b0;
      chk("mid_rst_en", {31'd0, cpu_en}, 32'd0);
      chk("mid_rst_state", 32'(state), 32'(ST_HALT));
      chk_counts("mid_rst");
      repeat (10) tick();
      chk("post_rst_state", 32'(state), 32'(ST_HALT));
      chk_counts("post_rst");

`ifdef CPU_CLOCK_RUN_LIMIT_EN
      begin
         int pulses = 0;
         run_limit = 5;
         mode_run = 1'b1;
         for (int i = 0; i < 40; i++) begin
            tick();
            if (cpu_en === 1'b1) pulses++;
         end
         chk("limit_pulses", pulses, 5);
         chk("limit_state", 32'(state), 32'(ST_BRK));
         mode_run = 1'b0;
         tick();
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
